// File: rtl/present_decrypt.sv
// present_decrypt: iterative PRESENT block-cipher decryptor, one inverse round per cycle
// Ports:
//   Clock, Reset    rising-edge clock, asynchronous active-low reset
//   clear           synchronous abort back to IDLE
//   in_valid/ready  input handshake; key_in and ciphertext sampled only on acceptance
//   out_valid/ready output handshake; plaintext held until accepted
//   plaintext       decrypted block (the state register)
//   round           current round counter, for debug
// The forward key schedule is run first to reach K32; each inverse round then
// recomputes the previous round key, so no key table is kept.
module present_decrypt #(
   parameter int KEY_SIZE   = 80,
   parameter int BLOCK_SIZE = 64,
   parameter int NUM_ROUNDS = 31
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [KEY_SIZE-1:0]   key_in,
   input  logic [BLOCK_SIZE-1:0] ciphertext,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BLOCK_SIZE-1:0] plaintext,
   output logic [4:0]            round
);
   localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
   localparam logic [63:0] SINV = 64'hA970364BD21C8FE5;
   localparam logic [4:0]  LAST = 5'(NUM_ROUNDS);

   typedef enum logic [2:0] {IDLE, EXPAND, WHITEN, DECRYPT, DONE} fsm_t;

   function automatic logic [3:0] sb(input logic [3:0] x);
      return SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] sbi(input logic [3:0] x);
      return SINV[{x, 2'b00} +: 4];
   endfunction

   fsm_t                fsm;
   logic [63:0]         state, rk, perm, round_out;
   logic [KEY_SIZE-1:0] key, key_up, key_dn;
   logic [4:0]          dn_idx;

   assign plaintext = state;
   assign rk        = key[KEY_SIZE-1 -: 64];
   // WHITEN steps K32 back to K31; each DECRYPT round steps Kr back to K(r-1)
   assign dn_idx    = fsm == WHITEN ? round : round - 5'd1;

   if (BLOCK_SIZE != 64 || NUM_ROUNDS != 31) begin : g_bad_size
      $error("present_decrypt: BLOCK_SIZE must be 64 and NUM_ROUNDS 31");
   end

   if (KEY_SIZE == 80) begin : g_k80
      logic [79:0] r, t;
      assign r      = {key[18:0], key[79:19]};
      assign key_up = {sb(r[79:76]), r[75:20], r[19:15] ^ round, r[14:0]};
      assign t      = {sbi(key[79:76]), key[75:20], key[19:15] ^ dn_idx, key[14:0]};
      assign key_dn = {t[60:0], t[79:61]};
   end else if (KEY_SIZE == 128) begin : g_k128
      logic [127:0] r, t;
      assign r      = {key[66:0], key[127:67]};
      assign key_up = {sb(r[127:124]), sb(r[123:120]), r[119:67], r[66:62] ^ round, r[61:0]};
      assign t      = {sbi(key[127:124]), sbi(key[123:120]), key[119:67], key[66:62] ^ dn_idx, key[61:0]};
      assign key_dn = {t[60:0], t[127:61]};
   end else begin : g_bad_key
      $error("present_decrypt: KEY_SIZE must be 80 or 128");
   end

   // inverse bit permutation: output bit j takes input bit 16j mod 63 (bit 63 fixed)
   for (genvar j = 0; j < 64; j++) begin : g_p
      assign perm[j] = state[j == 63 ? 63 : (16 * j) % 63];
   end

   for (genvar n = 0; n < 16; n++) begin : g_s
      assign round_out[4*n +: 4] = sbi(perm[4*n +: 4]) ^ rk[4*n +: 4];
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         fsm       <= IDLE;
         state     <= '0;
         key       <= '0;
         round     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (clear) begin
         fsm       <= IDLE;
         round     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state    <= ciphertext;
               key      <= key_in;
               round    <= 5'd1;
               in_ready <= 1'b0;
               fsm      <= EXPAND;
            end
            EXPAND: begin
               key   <= key_up;
               round <= round == LAST ? round : round + 5'd1;
               fsm   <= round == LAST ? WHITEN : EXPAND;
            end
            WHITEN: begin
               state <= state ^ rk;
               key   <= key_dn;
               round <= LAST;
               fsm   <= DECRYPT;
            end
            DECRYPT: begin
               state <= round_out;
               if (round == 5'd1) begin
                  round     <= '0;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  key   <= key_dn;
                  round <= round - 5'd1;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               fsm       <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_present_decrypt.sv
// tb_present_decrypt: scoreboard bench for present_decrypt with 80- and 128-bit key instances
module tb_present_decrypt;
   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   logic         Clock, Reset, clear;
   logic         iv [2];
   logic         ir [2];
   logic         ov [2];
   logic         ordy [2];
   logic [127:0] kin [2];
   logic [63:0]  ct [2];
   logic [63:0]  pt [2];
   logic [4:0]   rd [2];
   logic [63:0]  q0 [$];
   logic [63:0]  q1 [$];
   int           checks = 0;
   int           errors = 0;

   present_decrypt #(.KEY_SIZE(80)) dut80 (
      .Clock(Clock), .Reset(Reset), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
      .key_in(kin[0][79:0]), .ciphertext(ct[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .plaintext(pt[0]), .round(rd[0]));

   present_decrypt #(.KEY_SIZE(128)) dut128 (
      .Clock(Clock), .Reset(Reset), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
      .key_in(kin[1]), .ciphertext(ct[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .plaintext(pt[1]), .round(rd[1]));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Reference PRESENT encryptor built straight from the cipher definition
   function automatic logic [63:0] encrypt(input logic [127:0] key, input int ks, input logic [63:0] p);
      logic [127:0] k, n;
      logic [63:0]  s, o;
      k = ks == 80 ? {48'd0, key[79:0]} : key;
      s = p;
      o = '0;
      for (int i = 1; i <= 31; i++) begin
         s = s ^ k[ks-64 +: 64];
         for (int b = 0; b < 16; b++) s[4*b +: 4] = SB[s[4*b +: 4]];
         for (int b = 0; b < 64; b++) o[b == 63 ? 63 : (16 * b) % 63] = s[b];
         s = o;
         n = '0;
         for (int b = 0; b < ks; b++) n[(b + 61) % ks] = k[b];
         n[ks-4 +: 4] = SB[n[ks-4 +: 4]];
         if (ks == 128) n[ks-8 +: 4] = SB[n[ks-8 +: 4]];
         k = n ^ (128'(i) << (ks == 80 ? 15 : 62));
      end
      return s ^ k[ks-64 +: 64];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every transfer on the output side is matched against the scoreboard
   always @(negedge Clock) begin
      for (int s = 0; s < 2; s++) begin
         if (ov[s] && ordy[s]) begin
            if ((s == 0 ? q0.size() : q1.size()) == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output dut%0d: got %h with nothing expected", s, pt[s]);
            end else if (s == 0) check("plaintext80", pt[0], q0.pop_front());
            else check("plaintext128", pt[1], q1.pop_front());
         end
      end
   end

   task automatic send(input int s, input logic [127:0] k, input logic [63:0] c,
                       input logic [63:0] e, input bit push);
      bit r;
      int t;
      r = 0;
      t = 0;
      iv[s]  = 1'b1;
      kin[s] = k;
      ct[s]  = c;
      while (!r && t < 300) begin
         @(negedge Clock);
         r = ir[s];
         t++;
         @(posedge Clock);
         #1;
      end
      iv[s]  = 1'b0;
      kin[s] = ~k;
      ct[s]  = ~c;
      check("accept", 64'(r), 64'd1);
      if (r && push) begin
         if (s == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 400) begin
         @(posedge Clock);
         t++;
      end
      check("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
      @(posedge Clock);
      #1;
   endtask

   initial begin
      logic [127:0] ones;
      int           t;
      ones = '1;
      Reset = 1'b0;
      clear = 1'b0;
      for (int s = 0; s < 2; s++) begin
         iv[s] = 1'b0; ordy[s] = 1'b1; kin[s] = '0; ct[s] = '0;
      end
      repeat (2) @(posedge Clock);
      #1;
      check("reset_in_ready80", 64'(ir[0]), 64'd1);
      check("reset_out_valid80", 64'(ov[0]), 64'd0);
      check("reset_round80", 64'(rd[0]), 64'd0);
      check("reset_plaintext80", pt[0], 64'd0);
      check("reset_in_ready128", 64'(ir[1]), 64'd1);
      check("reset_round128", 64'(rd[1]), 64'd0);
      Reset = 1'b1;
      @(posedge Clock);
      #1;

      check("model80_zero", encrypt('0, 80, '0), 64'h5579C1387B228445);
      check("model80_ones", encrypt(ones, 80, '1), 64'h3333DCD3213210D2);
      check("model128_zero", encrypt('0, 128, '0), 64'h96DB702A2E6900AF);

      // known vector with exact latency and debug round counter
      send(0, '0, 64'h5579C1387B228445, 64'h0, 1);
      repeat (10) @(posedge Clock);
      #1;
      check("round_expand", 64'(rd[0]), 64'd11);
      repeat (52) @(posedge Clock);
      #1;
      check("latency_62", 64'(ov[0]), 64'd0);
      @(posedge Clock);
      #1;
      check("latency_63", 64'(ov[0]), 64'd1);
      drain();

      send(0, ones, 64'h3333DCD3213210D2, '1, 1);
      drain();

      // back-to-back blocks: second send waits out the busy period
      send(0, ones, 64'hE72C46C0F5945049, 64'h0, 1);
      check("busy_in_ready", 64'(ir[0]), 64'd0);
      send(0, '0, 64'hA112FFC72F68417B, '1, 1);
      check("busy_in_ready2", 64'(ir[0]), 64'd0);
      drain();

      send(1, '0, 64'h96DB702A2E6900AF, 64'h0, 1);
      drain();

      // backpressure: plaintext and out_valid hold while out_ready is low
      ordy[0] = 1'b0;
      send(0, ones, 64'hE72C46C0F5945049, 64'h0, 1);
      t = 0;
      while (!ov[0] && t < 100) begin
         @(posedge Clock);
         #1;
         t++;
      end
      check("bp_out_valid", 64'(ov[0]), 64'd1);
      repeat (20) begin
         @(posedge Clock);
         #1;
         check("bp_hold_valid", 64'(ov[0]), 64'd1);
         check("bp_hold_plaintext", pt[0], 64'h0);
      end
      ordy[0] = 1'b1;
      @(posedge Clock);
      #1;
      check("bp_released_valid", 64'(ov[0]), 64'd0);
      check("bp_released_ready", 64'(ir[0]), 64'd1);
      drain();

      // clear during DECRYPT round 10
      send(0, ones, 64'hE72C46C0F5945049, 64'h0, 0);
      repeat (53) @(posedge Clock);
      #1;
      check("clear_round_before", 64'(rd[0]), 64'd10);
      clear = 1'b1;
      @(posedge Clock);
      #1;
      clear = 1'b0;
      check("clear_out_valid", 64'(ov[0]), 64'd0);
      check("clear_round", 64'(rd[0]), 64'd0);
      check("clear_in_ready", 64'(ir[0]), 64'd1);
      repeat (80) @(posedge Clock);
      #1;

      // clear beats in_valid in IDLE
      iv[0] = 1'b1;
      clear = 1'b1;
      @(posedge Clock);
      #1;
      clear = 1'b0;
      iv[0] = 1'b0;
      check("clear_vs_valid_ready", 64'(ir[0]), 64'd1);
      check("clear_vs_valid_round", 64'(rd[0]), 64'd0);

      // asynchronous reset during EXPAND, then a fresh block
      send(0, ones, 64'h3333DCD3213210D2, '1, 0);
      repeat (5) @(posedge Clock);
      #3;
      Reset = 1'b0;
      #1;
      check("areset_out_valid", 64'(ov[0]), 64'd0);
      check("areset_in_ready", 64'(ir[0]), 64'd1);
      check("areset_round", 64'(rd[0]), 64'd0);
      check("areset_plaintext", pt[0], 64'd0);
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      send(0, '0, 64'h5579C1387B228445, 64'h0, 1);
      drain();

      // random loopback through the reference encryptor, both key sizes in parallel
      fork
         for (int i = 0; i < 500; i++) begin
            logic [127:0] k;
            logic [63:0]  p;
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom};
            send(0, k, encrypt(k, 80, p), p, 1);
         end
         for (int i = 0; i < 500; i++) begin
            logic [127:0] k;
            logic [63:0]  p;
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom};
            send(1, k, encrypt(k, 128, p), p, 1);
         end
      join
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
